ikaopll_bus_writer: RTL and testbench

- Host-side bus master that drives the OPLL CPU write port (CS_n, WR_n, A0, D) from a valid/ready register-write request stream.
- Enforces the OPLL write protocol:
  - an address write, then a data write;
  - a WR_n strobe of a fixed width;
  - mandatory wait periods counted in phiM clock enables, so the core's internal timing generator has consumed each write before the next one arrives.
- Used by the bench and by MSX glue that replays register streams into the OPLL.

---
 rtl/ikaopll_bus_pkg.sv | 28 ++
 rtl/ikaopll_bus_writer_if.sv | 24 ++
 rtl/ikaopll_bus_writer_tick.sv | 23 ++
 rtl/ikaopll_bus_writer.sv | 135 +++++++++++++
 tb/tb_ikaopll_bus_writer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ikaopll_bus_pkg.sv
// Shared types and default timing for the OPLL host write-port master.
// The state encoding and the request struct are shared by the writer and its users.
package ikaopll_bus_pkg;

    localparam int ADDR_WAIT_DEF = 12;
    localparam int DATA_WAIT_DEF = 84;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_A_SETUP  = 3'd1,
        ST_A_STROBE = 3'd2,
        ST_A_WAIT   = 3'd3,
        ST_D_SETUP  = 3'd4,
        ST_D_STROBE = 3'd5,
        ST_D_WAIT   = 3'd6
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    // Counter loads are 8 bits; the range is checked at elaboration.
    function automatic logic [7:0] ticks8(input int unsigned v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/ikaopll_bus_writer_if.sv
// Request handshake plus OPLL CPU write-port signals of the bus writer.
// master = request source / bus observer, slave = the writer itself.
interface ikaopll_bus_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, cs_n, wr_n, a0, d, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, cs_n, wr_n, a0, d, busy, done
    );
endinterface

// File: rtl/ikaopll_bus_writer_tick.sv
// Loadable down-counter advanced only on phiM ticks; o_TERM marks the
// tick on which the current phase ends (count==1 and a tick is present).
module ikaopll_tick_counter (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_LOAD,
    input  logic [7:0] i_LOAD_VAL,
    output logic       o_TERM
);
    logic [7:0] r_cnt;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST)
            r_cnt <= 8'd0;
        else if (i_LOAD)
            r_cnt <= i_LOAD_VAL;
        else if (!i_phiM_PCEN_n && r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
    end

    assign o_TERM = !i_phiM_PCEN_n && (r_cnt == 8'd1);
endmodule

// File: rtl/ikaopll_bus_writer.sv
// Drives the OPLL CPU write port from a valid/ready request stream:
// address write, data write, each followed by a phiM-tick-counted wait.
module ikaopll_bus_writer
    import ikaopll_bus_pkg::*;
#(
    parameter int SETUP_TICKS    = 1,
    parameter int WR_TICKS       = 2,
    parameter int ADDR_WAIT      = ADDR_WAIT_DEF,
    parameter int DATA_WAIT      = DATA_WAIT_DEF,
    parameter bit SKIP_SAME_ADDR = 1'b0
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_REQ_VALID,
    output logic       o_REQ_READY,
    input  logic [7:0] i_REQ_ADDR,
    input  logic [7:0] i_REQ_DATA,
    output logic       o_CS_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_BUSY,
    output logic       o_DONE
);

    if (SETUP_TICKS < 1 || SETUP_TICKS > 255 || WR_TICKS < 1 || WR_TICKS > 255 ||
        ADDR_WAIT < 1 || ADDR_WAIT > 255 || DATA_WAIT < 1 || DATA_WAIT > 255) begin : g_param_check
        $error("ikaopll_bus_writer: timing parameters must be within 1..255");
    end

    state_t     r_state;
    state_t     w_state_next;
    req_t       r_req;
    logic [7:0] r_last_addr;
    logic       r_last_valid;
    logic       r_done;
    logic       w_accept;
    logic       w_skip;
    logic       w_load;
    logic       w_term;
    logic [7:0] w_load_val;

    assign w_accept = i_REQ_VALID && o_REQ_READY;
    assign w_skip   = SKIP_SAME_ADDR && r_last_valid && (i_REQ_ADDR == r_last_addr);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_state_next = w_skip ? ST_D_SETUP : ST_A_SETUP;
            ST_A_SETUP:  if (w_term) w_state_next = ST_A_STROBE;
            ST_A_STROBE: if (w_term) w_state_next = ST_A_WAIT;
            ST_A_WAIT:   if (w_term) w_state_next = ST_D_SETUP;
            ST_D_SETUP:  if (w_term) w_state_next = ST_D_STROBE;
            ST_D_STROBE: if (w_term) w_state_next = ST_D_WAIT;
            ST_D_WAIT:   if (w_term) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Every state change reloads the counter with the duration of the state being entered.
    assign w_load = (w_state_next != r_state);

    always_comb begin
        w_load_val = 8'd0;
        case (w_state_next)
            ST_A_SETUP, ST_D_SETUP:   w_load_val = ticks8(SETUP_TICKS);
            ST_A_STROBE, ST_D_STROBE: w_load_val = ticks8(WR_TICKS);
            ST_A_WAIT:                w_load_val = ticks8(ADDR_WAIT);
            ST_D_WAIT:                w_load_val = ticks8(DATA_WAIT);
            default:                  w_load_val = 8'd0;
        endcase
    end

    ikaopll_tick_counter u_tick (
        .i_EMUCLK      (i_EMUCLK),
        .i_RST         (i_RST),
        .i_phiM_PCEN_n (i_phiM_PCEN_n),
        .i_LOAD        (w_load),
        .i_LOAD_VAL    (w_load_val),
        .o_TERM        (w_term)
    );

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            r_req        <= '0;
            r_last_addr  <= 8'd0;
            r_last_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_accept)
                r_req <= '{addr: i_REQ_ADDR, data: i_REQ_DATA};
            if (r_state == ST_A_STROBE && w_term) begin
                r_last_addr  <= r_req.addr;
                r_last_valid <= 1'b1;
            end
            r_done <= (r_state == ST_D_WAIT) && w_term;
        end
    end

    always_comb begin
        o_CS_n      = 1'b1;
        o_WR_n      = 1'b1;
        o_A0        = 1'b0;
        o_D         = 8'd0;
        o_REQ_READY = 1'b0;
        o_BUSY      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_REQ_READY = 1'b1;
                o_BUSY      = 1'b0;
            end
            ST_A_SETUP:  begin o_CS_n = 1'b0; o_D = r_req.addr; end
            ST_A_STROBE: begin o_CS_n = 1'b0; o_WR_n = 1'b0; o_D = r_req.addr; end
            ST_A_WAIT:   o_D = r_req.addr;
            ST_D_SETUP:  begin o_CS_n = 1'b0; o_A0 = 1'b1; o_D = r_req.data; end
            ST_D_STROBE: begin o_CS_n = 1'b0; o_WR_n = 1'b0; o_A0 = 1'b1; o_D = r_req.data; end
            ST_D_WAIT:   begin o_A0 = 1'b1; o_D = r_req.data; end
            default: begin
                o_REQ_READY = 1'b0;
                o_BUSY      = 1'b1;
            end
        endcase
    end

    assign o_DONE = r_done;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Scoreboard bench: instance 0 skips repeated addresses, instance 1 never does.
// Stimulus pushes expected strobes and per-request tick totals; a monitor pops them.
module tb_ikaopll_bus_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcen_n = 1'b1;
    bit         freeze = 1'b0;

    logic       req_valid [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_data  [2];
    logic       ready [2];
    logic       cs_n  [2];
    logic       wr_n  [2];
    logic       a0    [2];
    logic [7:0] d     [2];
    logic       busy  [2];
    logic       done  [2];

    typedef struct { int inst; int a0; int d; } strb_t;
    typedef struct { int inst; int ticks; } tot_t;
    strb_t strb_q[$];
    tot_t  tot_q[$];
    strb_t e_s;
    tot_t  e_t;

    bit         lastv  [2];
    logic [7:0] last_a [2];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        ikaopll_bus_writer_if bus ();
        assign bus.req_valid = req_valid[gi];
        assign bus.req_addr  = req_addr[gi];
        assign bus.req_data  = req_data[gi];
        assign ready[gi] = bus.req_ready;
        assign cs_n[gi]  = bus.cs_n;
        assign wr_n[gi]  = bus.wr_n;
        assign a0[gi]    = bus.a0;
        assign d[gi]     = bus.d;
        assign busy[gi]  = bus.busy;
        assign done[gi]  = bus.done;

        ikaopll_bus_writer #(.SKIP_SAME_ADDR(gi == 0 ? 1'b1 : 1'b0)) u_dut (
            .i_EMUCLK      (clk),
            .i_RST         (rst),
            .i_phiM_PCEN_n (pcen_n),
            .i_REQ_VALID   (bus.req_valid),
            .o_REQ_READY   (bus.req_ready),
            .i_REQ_ADDR    (bus.req_addr),
            .i_REQ_DATA    (bus.req_data),
            .o_CS_n        (bus.cs_n),
            .o_WR_n        (bus.wr_n),
            .o_A0          (bus.a0),
            .o_D           (bus.d),
            .o_BUSY        (bus.busy),
            .o_DONE        (bus.done)
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // phiM tick on every 4th EMUCLK, changed just after the rising edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            pcen_n = freeze || (ph != 0);
        end
    end

    // Monitor: strobe contents/width and ticks per request, checked at each falling edge.
    initial begin
        int  tick_cnt [2];
        int  stb_ticks[2];
        bit  in_stb   [2];
        bit  prev_wr  [2];
        bit  prev_done[2];
        for (int k = 0; k < 2; k++) begin
            tick_cnt[k] = 0; stb_ticks[k] = 0; in_stb[k] = 0; prev_wr[k] = 1; prev_done[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    tick_cnt[k] = 0; in_stb[k] = 0; prev_wr[k] = 1; prev_done[k] = 0;
                end else begin
                    if (busy[k] && !pcen_n) tick_cnt[k]++;
                    if (!wr_n[k] && prev_wr[k]) begin
                        chk("strobe_expected", int'(strb_q.size() > 0), 1);
                        if (strb_q.size() > 0) begin
                            e_s = strb_q.pop_front();
                            chk("strobe_inst", k, e_s.inst);
                            chk("strobe_a0", int'(a0[k]), e_s.a0);
                            chk("strobe_d", int'(d[k]), e_s.d);
                            chk("strobe_cs_n", int'(cs_n[k]), 0);
                        end
                        in_stb[k] = 1;
                        stb_ticks[k] = 0;
                    end
                    if (!wr_n[k] && !pcen_n) stb_ticks[k]++;
                    if (wr_n[k] && !prev_wr[k] && in_stb[k]) begin
                        chk("strobe_width", stb_ticks[k], 2);
                        in_stb[k] = 0;
                    end
                    if (done[k]) begin
                        chk("done_expected", int'(tot_q.size() > 0), 1);
                        if (tot_q.size() > 0) begin
                            e_t = tot_q.pop_front();
                            chk("done_inst", k, e_t.inst);
                            chk("request_ticks", tick_cnt[k], e_t.ticks);
                            $display("inst%0d request done after %0d ticks (expected %0d)",
                                     k, tick_cnt[k], e_t.ticks);
                        end
                        chk("done_ready", int'(ready[k]), 1);
                        chk("done_single_pulse", int'(prev_done[k]), 0);
                        tick_cnt[k] = 0;
                    end
                    prev_wr[k]   = wr_n[k];
                    prev_done[k] = done[k];
                end
            end
        end
    end

    // Must be entered right after a falling edge.
    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] dt);
        int n;
        bit sk;
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_data[k]  = dt;
        n = 0;
        while (!ready[k] && n < 3000) begin
            chk("busy_when_not_ready", int'(busy[k]), 1);
            @(negedge clk);
            n++;
        end
        chk("accepted_in_time", int'(ready[k]), 1);
        sk = (k == 0) && lastv[k] && (last_a[k] == a);
        if (!sk) strb_q.push_back('{inst: k, a0: 0, d: int'(a)});
        strb_q.push_back('{inst: k, a0: 1, d: int'(dt)});
        tot_q.push_back('{inst: k, ticks: sk ? (1 + 2 + 84) : (1 + 2 + 12 + 1 + 2 + 84)});
        lastv[k]  = 1'b1;
        last_a[k] = a;
        @(negedge clk);
        req_valid[k] = 1'b0;
        chk("ready_low_after_accept", int'(ready[k]), 0);
        chk("busy_after_accept", int'(busy[k]), 1);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((busy[k] || strb_q.size() != 0 || tot_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_time", int'(n < 3000), 1);
    endtask

    // which: 0 = A_WAIT, 1 = D_STROBE
    task automatic wait_state(input int k, input int which);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? (busy[k] && cs_n[k] && !a0[k]) : (!wr_n[k] && a0[k]);
        end
        chk("state_reached", int'(hit), 1);
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        chk({tag, "_cs_n"}, int'(cs_n[k]), 1);
        chk({tag, "_wr_n"}, int'(wr_n[k]), 1);
        chk({tag, "_ready"}, int'(ready[k]), 1);
        chk({tag, "_busy"}, int'(busy[k]), 0);
        chk({tag, "_done"}, int'(done[k]), 0);
    endtask

    initial begin
        logic       s_cs, s_wr, s_a0, s_busy;
        logic [7:0] s_d;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_addr[k] = 0; req_data[k] = 0; lastv[k] = 0; last_a[k] = 0;
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_idle_outputs(k, "reset");
            chk("reset_a0", int'(a0[k]), 0);
            chk("reset_d", int'(d[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single request, defaults: 102 ticks.
        issue(0, 8'h10, 8'h55);
        wait_idle(0);

        // Same address twice with skipping enabled: 102 then 87 ticks.
        issue(0, 8'h30, 8'h01);
        issue(0, 8'h30, 8'h02);
        wait_idle(0);

        // Second request waits while busy; its data must not leak onto D.
        issue(0, 8'h40, 8'h55);
        issue(0, 8'h41, 8'hAA);
        wait_idle(0);

        // Freeze the tick enable for 50 clocks inside A_WAIT.
        issue(0, 8'h50, 8'h11);
        wait_state(0, 0);
        @(negedge clk);
        freeze = 1'b1;
        @(negedge clk);
        s_cs = cs_n[0]; s_wr = wr_n[0]; s_a0 = a0[0]; s_d = d[0]; s_busy = busy[0];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("freeze_cs_n", int'(cs_n[0]), int'(s_cs));
            chk("freeze_wr_n", int'(wr_n[0]), int'(s_wr));
            chk("freeze_a0", int'(a0[0]), int'(s_a0));
            chk("freeze_d", int'(d[0]), int'(s_d));
            chk("freeze_busy", int'(busy[0]), int'(s_busy));
        end
        chk("freeze_in_a_wait", int'(s_cs && s_busy && !s_a0 && (s_d == 8'h50)), 1);
        freeze = 1'b0;
        wait_idle(0);

        // Reset during D_STROBE aborts; address memory is forgotten.
        issue(0, 8'h60, 8'h22);
        wait_state(0, 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        strb_q.delete();
        tot_q.delete();
        lastv[0] = 0;
        lastv[1] = 0;
        @(negedge clk);
        issue(0, 8'h60, 8'h33);
        wait_idle(0);

        // No skipping on instance 1: both requests take 102 ticks.
        issue(1, 8'h30, 8'h01);
        issue(1, 8'h30, 8'h02);
        wait_idle(1);

        chk("strobe_queue_empty", strb_q.size(), 0);
        chk("total_queue_empty", tot_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
